// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and defaults.
// Macro IF_PERF_CNT_EN enables the saturating counter helper's users.
package if_fetch_stage_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 8;

  localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;
  localparam logic [7:0] NOP_INSTR       = 8'h00;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_op_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        en
  );
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/if_pc_counter.sv
// PC register: hold, increment (wraps mod 2^PC_W) or load target.
// Ports: clk, reset (async active-low), op, target in; pc out.
module if_pc_counter
  import if_fetch_stage_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  pc_op_e          op,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      unique case (op)
        PC_LOAD: pc <= target;
        PC_INC:  pc <= pc + 1'b1;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC, IF/ID register, BOOT/RUN/HALT FSM, Flush to ID/EX.
// Ports: clk, reset, stall, branch_*, imem_* ; IF_ID_*, Flush, halted; IF_PERF_CNT_EN adds perf_*.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int                 PC_W        = PC_W_DEF,
  parameter int                 INSTR_W     = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [PC_W-1:0]    RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic [PC_W-1:0]    IF_ID_PC,
  output logic               IF_ID_valid,
  output logic               Flush,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushes,
  output logic [15:0]        perf_stalls,
`endif
  output logic               halted
);

  logic [1:0]         state;
  logic [1:0]         state_d;
  logic [PC_W-1:0]    pc;
  pc_op_e             pc_op;
  logic               ifid_we;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_d;
  logic               ifid_valid_d;

  logic is_halt;
  logic do_br;
  logic do_stall;
  logic do_halt;
  logic do_fetch;

  if_pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .op     (pc_op),
    .target (branch_target),
    .pc     (pc)
  );

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);
  assign Flush     = branch_taken & (state != ST_BOOT);

  // One-hot RUN decisions; redirect beats stall (stalled op is wrong-path).
  assign is_halt  = (imem_data == HALT_OPCODE);
  assign do_br    = branch_taken;
  assign do_stall = ~branch_taken & stall;
  assign do_halt  = ~branch_taken & ~stall & is_halt;
  assign do_fetch = ~branch_taken & ~stall & ~is_halt;

  always_comb begin
    pc_op        = PC_HOLD;
    state_d      = state;
    ifid_we      = 1'b0;
    ifid_instr_d = INSTR_W'(NOP_INSTR);
    ifid_pc_d    = '0;
    ifid_valid_d = 1'b0;
    case (state)
      ST_RUN: begin
        unique case (1'b1)
          do_br: begin
            pc_op   = PC_LOAD;
            ifid_we = 1'b1;
          end
          do_stall: begin
            ifid_we = 1'b0;
          end
          do_halt: begin
            ifid_we = 1'b1;
            state_d = ST_HALT;
          end
          do_fetch: begin
            pc_op        = PC_INC;
            ifid_we      = 1'b1;
            ifid_instr_d = imem_data;
            ifid_pc_d    = pc;
            ifid_valid_d = 1'b1;
          end
          default: begin
            ifid_we = 1'b0;
          end
        endcase
      end
      ST_HALT: begin
        ifid_we = 1'b1;
        if (branch_taken) begin
          pc_op   = PC_LOAD;
          state_d = ST_RUN;
        end
      end
      default: begin
        ifid_we = 1'b1;
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_BOOT;
      IF_ID_Instr <= '0;
      IF_ID_PC    <= '0;
      IF_ID_valid <= 1'b0;
    end else begin
      state <= state_d;
      if (ifid_we) begin
        IF_ID_Instr <= ifid_instr_d;
        IF_ID_PC    <= ifid_pc_d;
        IF_ID_valid <= ifid_valid_d;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
      perf_stalls  <= '0;
    end else begin
      perf_fetched <= sat_inc(perf_fetched, ifid_we & ifid_valid_d);
      perf_flushes <= sat_inc(perf_flushes, Flush);
      perf_stalls  <= sat_inc(perf_stalls,
                              (state == ST_RUN) & do_stall);
    end
  end
`endif

endmodule
